// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared widths and types for the PCM sample FIFO
package pcm_pkg;
  localparam int SAMPLE_W = 16;
  localparam int BYTE_W   = 8;

  typedef logic [15:0] pcm_sample_t;
  typedef enum logic {PH_HI, PH_LO} rd_phase_t;
endpackage

// File: rtl/pcm_sample_ram.sv
// rtl/pcm_sample_ram.sv - simple dual-port sample RAM, synchronous write and read
module pcm_sample_ram
  import pcm_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  pcm_sample_t              wd,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output pcm_sample_t              rd
);
  pcm_sample_t mem [DEPTH];

  // Read-first: a same-address write in the read cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/pcm_sample_fifo.sv
// rtl/pcm_sample_fifo.sv - PCM sample FIFO served as a high-byte-first byte stream
// Optional overflow/drop_count status is built when PCM_FIFO_STATUS_EN is defined.
module pcm_sample_fifo
  import pcm_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SAMPLE_W-1:0]    pcm_in,
  input  logic                   pcm_ready,
  input  logic                   flush,
  input  logic                   byte_req,
  output logic [BYTE_W-1:0]      byte_out,
  output logic                   byte_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t              wr_ptr, rd_ptr, wr_nxt, rd_nxt, lvl_nxt;
  rd_phase_t         phase;
  pcm_sample_t       ram_q;
  logic [BYTE_W-1:0] hold, lo_byte, byte_reg;
  logic              sel_hi, pend, pop, accept;

  assign pop     = byte_req && !flush && phase == PH_HI && !empty;
  assign accept  = pcm_ready && !flush && (!full || pop);
  assign wr_nxt  = wr_ptr + ptr_t'(accept);
  assign rd_nxt  = rd_ptr + ptr_t'(pop);
  assign lvl_nxt = wr_nxt - rd_nxt;

  // The popped word sits in ram_q for one cycle before being copied into hold.
  assign lo_byte  = pend ? ram_q[BYTE_W-1:0] : hold;
  assign byte_out = sel_hi ? ram_q[SAMPLE_W-1:BYTE_W] : byte_reg;

  pcm_sample_ram #(.DEPTH(DEPTH)) u_ram (
    .clk (clk),
    .we  (accept),
    .wa  (wr_ptr[AW-1:0]),
    .wd  (pcm_in),
    .re  (pop),
    .ra  (rd_ptr[AW-1:0]),
    .rd  (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      phase      <= PH_HI;
      hold       <= '0;
      pend       <= 1'b0;
      byte_reg   <= '0;
      sel_hi     <= 1'b0;
      byte_valid <= 1'b0;
    end else begin
      byte_valid <= byte_req;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
        empty  <= 1'b1;
        full   <= 1'b0;
        phase  <= PH_HI;
        hold   <= '0;
        pend   <= 1'b0;
        if (byte_req) begin
          byte_reg <= '0;
          sel_hi   <= 1'b0;
        end
      end else begin
        wr_ptr <= wr_nxt;
        rd_ptr <= rd_nxt;
        level  <= lvl_nxt;
        empty  <= (lvl_nxt == '0);
        full   <= (lvl_nxt == ptr_t'(DEPTH));
        pend   <= pop;
        hold   <= lo_byte;
        if (byte_req) begin
          if (phase == PH_LO) begin
            byte_reg <= lo_byte;
            sel_hi   <= 1'b0;
            phase    <= PH_HI;
          end else if (!empty) begin
            sel_hi <= 1'b1;
            phase  <= PH_LO;
          end else begin
            byte_reg <= '0;
            sel_hi   <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PCM_FIFO_STATUS_EN
  logic drop;
  assign drop = pcm_ready && !flush && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign overflow   = 1'b0;
  assign drop_count = '0;
`endif
endmodule

// File: tb/tb_pcm_sample_fifo.sv
// tb/tb_pcm_sample_fifo.sv - directed self-checking bench for pcm_sample_fifo
module tb_pcm_sample_fifo;
  localparam int DEPTH = 16;
`ifdef PCM_FIFO_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pcm_in = '0;
  logic        pcm_ready = 1'b0;
  logic        flush = 1'b0;
  logic        byte_req = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        empty;
  logic        full;
  logic [$clog2(DEPTH):0] level;
  logic        overflow;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pcm_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcm_in     (pcm_in),
    .pcm_ready  (pcm_ready),
    .flush      (flush),
    .byte_req   (byte_req),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic pr, input logic [15:0] d, input logic br, input logic fl);
    pcm_ready = pr;
    pcm_in    = d;
    byte_req  = br;
    flush     = fl;
    @(negedge clk);
    pcm_ready = 1'b0;
    byte_req  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_byte"},  byte_out, 0);
    check({tag, "_valid"}, byte_valid, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"},  full, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"},   overflow, 0);
    check({tag, "_drops"}, drop_count, 0);
  endtask

  initial begin
    logic [15:0] two_words [2];
    logic [7:0]  exp_bytes [4];
    int          exp_level [4];
    two_words = '{16'h1234, 16'hABCD};
    exp_bytes = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    exp_level = '{1, 1, 0, 0};

    repeat (2) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);

    // Underrun on an empty FIFO
    step(0, '0, 1, 0);
    check("under_valid", byte_valid, 1);
    check("under_byte",  byte_out, 8'h00);
    check("under_empty", empty, 1);
    check("under_level", level, 0);
    step(0, '0, 0, 0);
    check("idle_valid", byte_valid, 0);

    // Two samples, four back-to-back byte requests
    for (int i = 0; i < 2; i++) step(1, two_words[i], 0, 0);
    check("two_level", level, 2);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, 0);
      check($sformatf("two_byte%0d", i), byte_out, exp_bytes[i]);
      check($sformatf("two_valid%0d", i), byte_valid, 1);
      check($sformatf("two_level%0d", i), level, exp_level[i]);
    end
    step(0, '0, 0, 0);
    check("hold_byte",  byte_out, 8'hCD);
    check("hold_valid", byte_valid, 0);

    // Overfill by three
    for (int i = 0; i < DEPTH + 3; i++) step(1, 16'(i), 0, 0);
    check("fill_full",  full, 1);
    check("fill_level", level, DEPTH);
    check("fill_empty", empty, 0);
    check("fill_drops", drop_count, STAT ? 3 : 0);
    check("fill_ovf",   overflow, STAT ? 1 : 0);

    // Write while full, accepted because of the same-cycle pop
    step(1, 16'hBEEF, 1, 0);
    check("fullwr_byte",  byte_out, 8'h00);
    check("fullwr_level", level, DEPTH);
    check("fullwr_full",  full, 1);
    check("fullwr_drops", drop_count, STAT ? 3 : 0);
    step(0, '0, 1, 0);
    check("drain_lo0", byte_out, 8'h00);
    for (int i = 1; i < DEPTH; i++) begin
      step(0, '0, 1, 0);
      check($sformatf("drain_hi%0d", i), byte_out, 8'h00);
      step(0, '0, 1, 0);
      check($sformatf("drain_lo%0d", i), byte_out, i);
    end
    step(0, '0, 1, 0);
    check("drain_beef_hi", byte_out, 8'hBE);
    check("drain_empty",   empty, 1);
    step(0, '0, 1, 0);
    check("drain_beef_lo", byte_out, 8'hEF);

    // Flush from PH_LO with a concurrent write
    for (int i = 0; i < 5; i++) step(1, 16'h1100 + 16'(i), 0, 0);
    step(0, '0, 1, 0);
    check("pre_flush_byte", byte_out, 8'h11);
    step(1, 16'h7777, 0, 1);
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_full",  full, 0);
    check("flush_ovf",   overflow, 0);
    check("flush_drops", drop_count, 0);
    step(0, '0, 1, 0);
    check("post_flush_byte",  byte_out, 8'h00);
    check("post_flush_valid", byte_valid, 1);

    // byte_req in the flush cycle itself
    step(1, 16'h5566, 0, 0);
    step(0, '0, 1, 1);
    check("flushreq_byte",  byte_out, 8'h00);
    check("flushreq_valid", byte_valid, 1);
    check("flushreq_level", level, 0);

    // Asynchronous reset while in PH_LO
    step(1, 16'hA55A, 0, 0);
    step(1, 16'h0102, 0, 0);
    step(0, '0, 1, 0);
    check("mid_byte",  byte_out, 8'hA5);
    check("mid_level", level, 1);
    #1 rst = 1'b1;
    #1;
    check_reset_state("arst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    step(0, '0, 1, 0);
    check("after_rst_byte",  byte_out, 8'h00);
    check("after_rst_valid", byte_valid, 1);
    check("after_rst_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcm_sample_fifo.md
# pcm_sample_fifo

Buffers 16-bit PCM samples from the microphone decimation stage (`pcm_out`/`pcm_ready`) and serves them as a byte stream to the SPI slave readout path. Sits directly downstream of the PCM producer and upstream of the SPI shift register. Each sample is sent high byte first. Overflow is counted rather than stalling the producer, because the producer cannot be back-pressured.

## Interface

Parameters:
- `DEPTH`, 512, FIFO capacity in samples; power of two, ≥ 4.

Ports:
- `clk` in 1: system clock (25 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `pcm_in` in 16: PCM sample from the producer.
- `pcm_ready` in 1: one-cycle strobe; `pcm_in` is valid in that cycle.
- `flush` in 1: synchronous clear of contents and status.
- `byte_req` in 1: one-cycle strobe from the SPI slave requesting the next byte.
- `byte_out` out 8: returned byte.
- `byte_valid` out 1: one-cycle strobe qualifying `byte_out`.
- `empty` out 1: no stored samples.
- `full` out 1: `level == DEPTH`.
- `level` out `$clog2(DEPTH)+1`: number of stored samples.
- `overflow` out 1: sticky flag set when a sample is dropped.
- `drop_count` out 16: dropped-sample count; saturates at 0xFFFF.

## Operation

- Write acceptance: sample accepted when `pcm_ready && (!full || pop)`. `pop` is the read-side pop in the same cycle.
- Dropped samples: `pcm_ready` while full with no pop drops the new sample. On a drop, `overflow` goes to 1 and `drop_count` increments (saturating). Stored data is never overwritten.
- Read-phase FSM, states `PH_HI` and `PH_LO`; reset state is `PH_HI`.
  - `PH_HI` + `byte_req` + `!empty`: pop one sample, return `[15:8]`, keep `[7:0]` in a hold register, go to `PH_LO`.
  - `PH_HI` + `byte_req` + `empty`: underrun. Return 0x00 with `byte_valid`, no pop, stay in `PH_HI`.
  - `PH_LO` + `byte_req`: return the hold byte and go to `PH_HI`. This happens even if the FIFO has since gone empty.
  - No `byte_req`: no state change and no `byte_valid`.
- Flush:
  - Clears pointers, `level`, FSM (to `PH_HI`), hold register, `overflow` and `drop_count`.
  - Wins over `pcm_ready` in the same cycle; that sample is discarded and not counted.
  - `byte_req` in a flush cycle returns 0x00 with `byte_valid`.
- Pointers wrap modulo `DEPTH`. `level` is derived from an extra MSB on both pointers, never from a separate counter.

## Timing

- Reset values: `byte_out` = 0, `byte_valid` = 0, `empty` = 1, `full` = 0, `level` = 0, `overflow` = 0, `drop_count` = 0.
- Read latency: `byte_req` in cycle N gives `byte_out`/`byte_valid` in N+1. `byte_out` holds its value until the next `byte_valid`.
- Back-to-back `byte_req` is supported, one byte per cycle.
- Write visibility: `pcm_ready` at N updates `level`/`empty`/`full` at N+1. A `byte_req` at N+1 may read that sample; a `byte_req` at N sees the pre-write state.
- Simultaneous accepted write and pop: `level` is unchanged.
- Status flags and `level` are registered outputs.

## Configuration

- `PCM_FIFO_STATUS_EN` defined: `overflow` and `drop_count` behave as specified above.
- Undefined: `overflow` and `drop_count` are tied to 0 and their logic is removed. Drop behaviour itself (new sample discarded when full) is unchanged.

## Structure

- Shared package `pcm_pkg` holds:
  - `SAMPLE_W` = 16 and `BYTE_W` = 8.
  - `typedef logic [15:0] pcm_sample_t`.
  - `typedef enum logic {PH_HI, PH_LO} rd_phase_t`.
- Sub-module `pcm_sample_ram`: simple dual-port RAM of `DEPTH` × `pcm_sample_t`, synchronous write, synchronous read; infers block RAM.
- The pointer, status and read-FSM logic lives in the top module.

## Test plan

- Reset, then `byte_req` with no writes → `byte_out` = 0x00, `byte_valid` at N+1, `empty` = 1, `level` = 0.
- Write 0x1234, then 0xABCD, then 4× `byte_req` → bytes 0x12, 0x34, 0xAB, 0xCD; `level` goes 2→1→1→0→0.
- Write `DEPTH`+3 samples (value = index) with no reads:
  - `full` = 1, `level` = `DEPTH`, `drop_count` = 3, `overflow` = 1.
  - Draining returns indices 0..`DEPTH`-1 in order, high byte first.
- With FIFO full, `pcm_ready` and a `PH_HI` `byte_req` in the same cycle → write accepted, `level` stays `DEPTH`, `drop_count` unchanged.
- Write 5 samples, read only the high byte of the first, then `flush` together with `pcm_ready`:
  - `level` = 0, `empty` = 1, `overflow` = 0, `drop_count` = 0.
  - Next `byte_req` returns 0x00 (FSM is back in `PH_HI`).
- Assert `rst` mid-drain while in `PH_LO` → all outputs return to reset values immediately. After release, `byte_req` returns 0x00.
